seq_s2_driver: RTL and testbench

- Program sequencer that sits directly upstream of the two-register bank (RegBankS2) and drives its 12-bit `inst` / `inst_en` inputs.
- Fetches 16-bit program words from an external asynchronous-read ROM addressed by a program counter.
- Executes its own control opcodes (NOP, RUN, JMP, WAIT, HALT) and forwards RUN payloads to the bank as device instructions, at most one per cycle.

---
 rtl/seq_s2_driver.sv | 150 +++++++++++++++
 tb/tb_seq_s2_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_s2_driver.sv
// seq_s2_driver: program sequencer feeding the RegBankS2 instruction port.
// It fetches 16-bit words from an asynchronous-read ROM at pc, executes its
// own control opcodes, and forwards RUN payloads as single-cycle strobes.
module seq_s2_driver #(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_addr,
  input  logic                  hold,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [15:0]           prog,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_RUN  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_WAIT = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_en_q, inst_en_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [7:0]            cnt_q, cnt_d;

  logic [3:0]            opcode;
  logic [11:0]           payload;
  logic [PC_WIDTH-1:0]   pc_inc;

  assign opcode  = prog[15:12];
  assign payload = prog[11:0];
  // pc wraps naturally at 2^PC_WIDTH; wrap is not an error.
  assign pc_inc  = pc_q + PC_WIDTH'(1);

  // Next-state and output decode: one program word per EXEC cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the value.
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    inst_en_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // hold is deliberately ignored here; it takes effect in EXEC.
        if (start) begin
          pc_d    = start_addr;
          error_d = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (!hold) begin
          unique case (opcode)
            OP_NOP: pc_d = pc_inc;
            OP_RUN: begin
              inst_d    = payload[INST_WIDTH-1:0];
              inst_en_d = 1'b1;
              pc_d      = pc_inc;
            end
            OP_JMP: pc_d = payload[PC_WIDTH-1:0];
            OP_WAIT: begin
              // A zero count degenerates to NOP so no stall cycle is spent.
              if (payload[7:0] == 8'd0) begin
                pc_d = pc_inc;
              end else begin
                cnt_d   = payload[7:0];
                state_d = S_WAIT;
              end
            end
            OP_HALT: begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
            default: begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_WAIT: begin
        if (!hold) begin
          if (cnt_q == 8'd1) begin
            cnt_d   = 8'd0;
            pc_d    = pc_inc;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any RUN/WAIT.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before this edge, independent of ordering.
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_en_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_en_q <= inst_en_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc      = pc_q;
  assign inst    = inst_q;
  assign inst_en = inst_en_q;
  assign done    = done_q;
  assign error   = error_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_s2_driver.sv
// Testbench for seq_s2_driver: directed programs in a ROM model, a queue of
// expected instructions, and a monitor that pops on every inst_en strobe.
module tb_seq_s2_driver;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic        hold;
  logic [7:0]  pc;
  logic [15:0] prog;
  logic [11:0] inst;
  logic        inst_en;
  logic        busy;
  logic        done;
  logic        error;

  logic [15:0] rom [256];
  logic [11:0] exp_q [$];

  int n_total = 0;
  int n_pass  = 0;

  seq_s2_driver #(.PC_WIDTH(8), .INST_WIDTH(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .hold       (hold),
    .pc         (pc),
    .prog       (prog),
    .inst       (inst),
    .inst_en    (inst_en),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Asynchronous-read ROM.
  assign prog = rom[pc];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every issued instruction must match the head of the queue.
  always @(negedge clock) begin
    if (reset === 1'b0 && inst_en === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_inst_en", {20'd0, inst}, 32'hFFFF_FFFF);
      else check("inst_value", {20'd0, inst}, {20'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h4000;
  endtask

  task automatic do_start(input logic [7:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_sb_empty(input string name);
    check(name, exp_q.size(), 0);
  endtask

  int en_cnt;

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = 8'h00; hold = 1'b0;
    clear_rom();
    repeat (2) tick();
    reset = 1'b0;
    check("rst_pc",   {24'd0, pc}, 32'h0);
    check("rst_inst", {20'd0, inst}, 32'h0);
    check("rst_outs", {28'd0, inst_en, busy, done, error}, 32'h0);

    // Basic issue: two RUNs then HALT.
    clear_rom();
    rom[0] = 16'h11AE; rom[1] = 16'h1F01; rom[2] = 16'h4000;
    exp_q.push_back(12'h1AE); exp_q.push_back(12'hF01);
    do_start(8'h00);
    check("b_busy", {31'd0, busy}, 32'd1);
    tick(); check("b_en1", {31'd0, inst_en}, 32'd1); check("b_pc1", {24'd0, pc}, 32'h1);
    tick(); check("b_en2", {31'd0, inst_en}, 32'd1); check("b_pc2", {24'd0, pc}, 32'h2);
    tick(); check("b_done", {28'd0, inst_en, busy, done, error}, 32'b0010);
    check("b_pc_halt", {24'd0, pc}, 32'h2);
    tick(); check("b_done_pulse", {31'd0, done}, 32'd0);
    check("b_inst_hold", {20'd0, inst}, 32'hF01);
    check_sb_empty("b_sb");

    // Jump and pc wrap.
    clear_rom();
    rom[8'hFF] = 16'h1012; rom[8'h00] = 16'h2010; rom[8'h10] = 16'h4000;
    exp_q.push_back(12'h012);
    do_start(8'hFF);
    check("j_pc0", {24'd0, pc}, 32'hFF);
    tick(); check("j_pc1", {24'd0, pc}, 32'h00);
    tick(); check("j_pc2", {24'd0, pc}, 32'h10); check("j_en", {31'd0, inst_en}, 32'd0);
    tick(); check("j_done", {31'd0, done}, 32'd1); check("j_err", {31'd0, error}, 32'd0);
    check_sb_empty("j_sb");

    // WAIT 3: three stall cycles at pc 0.
    clear_rom();
    rom[0] = 16'h3003; rom[1] = 16'h1055; rom[2] = 16'h4000;
    exp_q.push_back(12'h055);
    do_start(8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w_stall", {23'd0, pc, inst_en}, {23'd0, 8'h00, 1'b0});
      check("w_busy", {31'd0, busy}, 32'd1);
    end
    tick(); check("w_resume_pc", {24'd0, pc}, 32'h1); check("w_resume_en", {31'd0, inst_en}, 32'd0);
    tick(); check("w_issue", {31'd0, inst_en}, 32'd1);
    tick(); check("w_done", {31'd0, done}, 32'd1);
    check_sb_empty("w_sb");

    // WAIT 0 behaves as NOP.
    clear_rom();
    rom[0] = 16'h3000; rom[1] = 16'h1055; rom[2] = 16'h4000;
    exp_q.push_back(12'h055);
    do_start(8'h00);
    tick(); check("w0_pc", {24'd0, pc}, 32'h1);
    tick(); check("w0_issue", {31'd0, inst_en}, 32'd1);
    wait_done("w0_done", 5);
    check_sb_empty("w0_sb");

    // Hold for four cycles after the first issue.
    clear_rom();
    rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h1003; rom[3] = 16'h4000;
    exp_q.push_back(12'h001); exp_q.push_back(12'h002); exp_q.push_back(12'h003);
    do_start(8'h00);
    tick(); check("h_first", {31'd0, inst_en}, 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("h_frozen", {23'd0, pc, inst_en}, {23'd0, 8'h01, 1'b0});
    end
    hold = 1'b0;
    tick(); check("h_res1", {23'd0, pc, inst_en}, {23'd0, 8'h02, 1'b1});
    tick(); check("h_res2", {23'd0, pc, inst_en}, {23'd0, 8'h03, 1'b1});
    tick(); check("h_done", {31'd0, done}, 32'd1);
    check_sb_empty("h_sb");

    // Illegal opcode, restart clears error, start while busy is ignored.
    clear_rom();
    rom[0] = 16'hF0AB;
    do_start(8'h00);
    tick(); check("i_flags", {28'd0, inst_en, busy, done, error}, 32'b0001);
    tick(); check("i_sticky", {31'd0, error}, 32'd1);
    rom[8'h20] = 16'h1077; rom[8'h21] = 16'h3002; rom[8'h22] = 16'h4000;
    exp_q.push_back(12'h077);
    do_start(8'h20);
    check("i_clear", {30'd0, busy, error}, 32'b10);
    check("i_pc", {24'd0, pc}, 32'h20);
    tick(); check("i_run", {31'd0, inst_en}, 32'd1);
    tick();
    start = 1'b1; start_addr = 8'h00;
    tick(); start = 1'b0;
    check("i_ign_start", {24'd0, pc}, 32'h21);
    tick(); check("i_resume", {24'd0, pc}, 32'h22);
    tick(); check("i_done", {30'd0, done, error}, 32'b10);
    check_sb_empty("i_sb");

    // Reset during a long WAIT aborts it.
    clear_rom();
    rom[0] = 16'h3020; rom[1] = 16'h1099; rom[2] = 16'h4000;
    do_start(8'h00);
    repeat (3) tick();
    check("r_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("r_outs", {28'd0, inst_en, busy, done, error}, 32'h0);
    check("r_pc", {24'd0, pc}, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inst_en === 1'b1 || busy === 1'b1) en_cnt++;
    end
    check("r_quiet", en_cnt, 0);
    exp_q.push_back(12'h099);
    do_start(8'h00);
    wait_done("r_restart_done", 60);
    check_sb_empty("r_sb");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
